// File: rtl/mem_arbiter.sv
// mem_arbiter: lets an instruction-fetch port and a data port share one
// single-port memory that has a fixed read latency.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE and returns to IDLE.
// By default, data wins a contended arbitration. A fetch starvation counter
// forces fetch to win after STARVE_MAX consecutive contended losses.
// Optional build macro: ARB_ROUND_ROBIN_EN. When it is defined, a contended
// arbitration goes to the requester that was not granted last, and the
// starvation counter is not built.
//
// Handshake: a requester holds req and its operands stable until it sees its
// ack. The ack is a one-cycle pulse in the DONE cycle. The arbiter samples
// requests only in IDLE, so a request that is still high after the ack is
// treated as a new request.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    logic [1:0]  state;
    logic        owner_fetch;
    logic        we_q;
    logic [3:0]  lat_cnt;
    logic [31:0] rd_q;
    logic        grant_fetch;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_fetch;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0]  starve_cnt;
`endif

    // Pick the winner of the current requests; only consumed while in IDLE.
    always_comb begin
        grant_fetch = 1'b0;
        if (i_req && !d_req) begin
            grant_fetch = 1'b1;
        end else if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_fetch = !last_fetch;
`else
            grant_fetch = (starve_cnt == STARVE_LIM);
`endif
        end
    end

    // Transaction FSM with the latched request, latency counter and read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            owner_fetch <= 1'b0;
            we_q        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            lat_cnt     <= '0;
            rd_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_fetch  <= 1'b0;
`else
            starve_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        owner_fetch <= grant_fetch;
                        m_addr      <= grant_fetch ? i_addr : d_addr;
                        we_q        <= grant_fetch ? 1'b0 : d_we;
                        m_wdata     <= grant_fetch ? 32'h0 : d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_fetch  <= grant_fetch;
`else
                        // A data grant while fetch is also asking is a contended loss.
                        if (grant_fetch) begin
                            starve_cnt <= '0;
                        end else if (i_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
`endif
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        rd_q  <= m_rdata;
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode: the memory strobe is active only in ISSUE, and the ack only in DONE.
    always_comb begin
        m_en      = (state == S_ISSUE);
        m_we      = (state == S_ISSUE) && we_q;
        i_ack     = (state == S_DONE) && owner_fetch;
        d_ack     = (state == S_DONE) && !owner_fetch;
        busy      = (state != S_IDLE);
        i_rdata   = rd_q;
        d_rdata   = rd_q;
        state_dbg = state;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2: cycles from the m_en cycle to the cycle m_rdata is valid; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 4: consecutive contended arbitrations lost by fetch before fetch is forced to win; legal range 1..15.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-006 i_addr  in  32  fetch word address, stable while i_req.
REQ-007 i_ack  out  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  out  32  fetched word, valid in the i_ack cycle.
REQ-009 d_req  in  1  data request, held until d_ack.
REQ-010 d_we  in  1  data write enable, stable while d_req.
REQ-011 d_addr, d_wdata  in  32 each  data address and store data, stable while d_req.
REQ-012 d_ack  out  1  one-cycle data completion pulse.
REQ-013 d_rdata  out  32  load data, valid in the d_ack cycle.
REQ-014 m_en, m_we  out  1 each  shared single-port memory strobe and write enable.
REQ-015 m_addr, m_wdata  out  32 each  memory address and store data.
REQ-016 m_rdata  in  32  memory read data.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE: if any request is present, the block SHALL latch the winner (owner, address, we, wdata) and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE: the block SHALL assert m_en for exactly one cycle with the latched m_addr, m_we and m_wdata, load lat_cnt=MEM_LAT-1, and go to WAIT.
REQ-021 WAIT: if lat_cnt is nonzero the block SHALL decrement it; when lat_cnt=0 it SHALL capture m_rdata into the read register and go to DONE.
REQ-022 DONE: the block SHALL pulse the owner's ack for one cycle and return to IDLE; the non-owner's ack SHALL stay 0.
REQ-023 Latency SHALL be MEM_LAT+2 cycles from the IDLE sampling edge to the ack cycle, and the next arbitration SHALL occur in the cycle after DONE.
REQ-024 i_rdata and d_rdata SHALL both be driven from the read register and SHALL hold their value until the next capture.
REQ-025 For a write, the captured value is don't-care; d_ack SHALL still pulse.
REQ-026 Outside the ISSUE cycle, m_en and m_we SHALL be 0.
REQ-027 The requester SHALL deassert or replace its request in the cycle after ack; a held request SHALL be treated as a new request.
REQ-028 Default arbitration under contention: data SHALL win.
REQ-029 starve_cnt SHALL increment on each contended loss by fetch, saturating at STARVE_MAX.
REQ-030 When starve_cnt=STARVE_MAX, fetch SHALL win the contended arbitration.
REQ-031 starve_cnt SHALL clear whenever fetch is granted.
REQ-032 An uncontended request SHALL always be granted.
REQ-033 Request-input changes outside IDLE SHALL be ignored.

Reset
REQ-034 Asserting reset SHALL immediately force IDLE and set busy, i_ack, d_ack, m_en and m_we to 0, the read register, m_addr and m_wdata to 0, and starve_cnt and lat_cnt to 0.
REQ-035 Reset mid-transaction SHALL abort it with no ack; after reset release, the first arbitration SHALL occur on the first clk edge.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester not granted last (last_owner reset=data, so fetch wins first), and the starvation logic SHALL be omitted.
REQ-037 Without ARB_ROUND_ROBIN_EN, REQ-028 through REQ-031 SHALL apply.

Verification
REQ-038 MEM_LAT=2; i_req alone with i_addr=0x10, memory word 0xE3A00001 -> m_en for one cycle with m_addr=0x10, i_ack 4 cycles after the sampling edge, i_rdata=0xE3A00001, d_ack=0.
REQ-039 d_req with d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> one m_en cycle with m_we=1, m_addr=0x20, m_wdata=0xDEADBEEF, then d_ack; a following read of 0x20 returns 0xDEADBEEF.
REQ-040 i_req and d_req both held continuously, STARVE_MAX=4, default build -> grant order D,D,D,D,I,D,D,D,D,I; with ARB_ROUND_ROBIN_EN -> I,D,I,D.
REQ-041 Reset asserted during WAIT -> m_en, busy and acks go to 0 immediately, no ack is ever issued for that request, and the next request completes normally.
REQ-042 MEM_LAT=1 and MEM_LAT=15 -> ack exactly 3 and 17 cycles after the sampling edge, with the read data matching memory.
